// File: rtl/led_out_port.sv
// rtl/led_out_port.sv - LED output port: CPU write FIFO feeding a held, registered 8-bit LED drive.
module led_out_port #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic                     clk_undiv,
  input  logic                     rst,
  input  logic                     io_we,
  input  logic [7:0]               io_wdata,
  output logic                     io_full,
  output logic                     io_busy,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               led
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(HOLD_CYCLES);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      led_q, led_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [DEPTH];

  logic push, drop, pop, empty;

  always_comb begin
    io_full  = (level_q == LW'(DEPTH));
    empty    = (level_q == '0);
    push     = io_we && !io_full;
    drop     = io_we && io_full;
    pop      = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    led_d    = led_q;

    // Pops look only at the pre-edge level, so a same-cycle write is never shown early.
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          led_d   = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          cnt_d = '0;
          if (!empty) begin
            pop   = 1'b1;
            led_d = mem_q[rd_ptr_q];
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk_undiv) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      led_q    <= 8'h00;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_undiv) begin
    if (!rst && push) mem_q[wr_ptr_q] <= io_wdata;
  end

  assign io_busy    = (state_q == SHOW) || !empty;
  assign ovf        = ovf_q;
  assign fifo_level = level_q;
  assign led        = led_q;

endmodule

// File: tb/tb_led_out_port.sv
// tb/tb_led_out_port.sv - self-checking bench for led_out_port with DEPTH=4, HOLD_CYCLES=4.
module tb_led_out_port;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic       clk_undiv = 1'b0;
  logic       rst = 1'b0;
  logic       io_we = 1'b0;
  logic [7:0] io_wdata = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       io_full, io_busy, ovf;
  logic [2:0] fifo_level;
  logic [7:0] led;

  led_out_port #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk_undiv (clk_undiv),
    .rst       (rst),
    .io_we     (io_we),
    .io_wdata  (io_wdata),
    .io_full   (io_full),
    .io_busy   (io_busy),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .fifo_level(fifo_level),
    .led       (led)
  );

  always #5 clk_undiv = ~clk_undiv;

  typedef struct packed {
    logic       rst;
    logic       we;
    logic [7:0] wd;
    logic [7:0] e_led;
    logic [2:0] e_lvl;
    logic       e_full;
    logic       e_busy;
    logic       e_ovf;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         cycle = 0;
  int         max_level = 0;
  bit         mon_en = 1'b0;
  logic [7:0] led_prev = 8'h00;
  logic [7:0] exp_q[$];
  int         chg_q[$];
  vec_t       vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Advance one edge, then sample; the scoreboard pops an expected value on every LED change.
  task automatic tick();
    @(posedge clk_undiv);
    #1;
    cycle++;
    if (mon_en && led !== led_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL led_unexpected_change: got %0h expected %0h (cycle %0d)", led, led_prev, cycle);
      end else begin
        chk("led_sequence", led, exp_q.pop_front());
      end
      chg_q.push_back(cycle);
    end
    led_prev = led;
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && (exp_q.size() != 0 || io_busy); i++) tick();
    chk("drain_busy", io_busy, 1'b0);
    chk("drain_scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic check_spacing(input string name, input int n);
    chk({name, "_changes"}, chg_q.size(), n);
    for (int i = 1; i < chg_q.size(); i++) chk({name, "_hold"}, chg_q[i] - chg_q[i-1], HOLD);
  endtask

  initial begin
    // Reset with writes pending, then a single write from idle, cycle by cycle.
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'hA5, 8'h00, 3'd1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'hA5, 3'd0, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b0, 8'h00, 8'hA5, 3'd0, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 2; i++) vecs.push_back('{1'b0, 1'b0, 8'h00, 8'hA5, 3'd0, 1'b0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      rst      = vecs[i].rst;
      io_we    = vecs[i].we;
      io_wdata = vecs[i].wd;
      tick();
      chk("vec_led",   led,        vecs[i].e_led);
      chk("vec_level", fifo_level, vecs[i].e_lvl);
      chk("vec_full",  io_full,    vecs[i].e_full);
      chk("vec_busy",  io_busy,    vecs[i].e_busy);
      chk("vec_ovf",   ovf,        vecs[i].e_ovf);
    end
    io_we = 1'b0;

    // Back-to-back writes: four-cycle holds, peak level of two.
    mon_en = 1'b1;
    chg_q.delete();
    max_level = 0;
    exp_q = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) begin
      io_we = 1'b1;
      io_wdata = 8'(i + 1);
      tick();
    end
    io_we = 1'b0;
    drain(40);
    check_spacing("t3", 3);
    chk("t3_peak_level", max_level, 2);
    chk("t3_led_final", led, 8'h03);

    // Six-write burst: fifth fills the FIFO, sixth is dropped.
    chg_q.delete();
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    for (int i = 0; i < 6; i++) begin
      io_we = 1'b1;
      io_wdata = 8'(8'h11 + i);
      tick();
      if (i == 4) begin
        chk("t4_full",       io_full,    1'b1);
        chk("t4_level_full", fifo_level, 3'd4);
        chk("t4_ovf_before", ovf,        1'b0);
      end
    end
    io_we = 1'b0;
    chk("t4_ovf_set", ovf, 1'b1);
    chk("t4_level_after_drop", fifo_level, 3'd3);
    drain(60);
    check_spacing("t4", 5);
    chk("t4_led_final", led, 8'h15);

    // Clear alone, then a drop coincident with a clear keeps the flag.
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t5_clr_alone", ovf, 1'b0);
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h27};
    for (int i = 0; i < 9; i++) begin
      io_we = 1'b1;
      io_wdata = 8'(8'h21 + i);
      ovf_clr = (i == 8);
      tick();
      if (i == 6) chk("t5_refilled", fifo_level, 3'd4);
      if (i == 7) chk("t5_ovf_set", ovf, 1'b1);
      if (i == 8) chk("t5_set_wins", ovf, 1'b1);
    end
    io_we = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t5_clr_again", ovf, 1'b0);

    // Reset mid-hold with two entries queued, then a fresh write.
    for (int i = 0; i < 20 && fifo_level != 3'd2; i++) tick();
    chk("t6_two_queued", fifo_level, 3'd2);
    chk("t6_in_show", io_busy, 1'b1);
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_led",   led,        8'h00);
    chk("t6_rst_level", fifo_level, 3'd0);
    chk("t6_rst_busy",  io_busy,    1'b0);
    chk("t6_rst_full",  io_full,    1'b0);
    tick();
    chk("t6_idle_led",  led,        8'h00);
    chk("t6_idle_busy", io_busy,    1'b0);
    exp_q = '{8'h3C};
    mon_en = 1'b1;
    io_we = 1'b1;
    io_wdata = 8'h3C;
    tick();
    io_we = 1'b0;
    chk("t6_latency_first_edge", led, 8'h00);
    tick();
    chk("t6_latency_second_edge", led, 8'h3C);
    drain(20);
    chk("t6_led_final", led, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
